// File: rtl/sram_train_ctrl.sv
// rtl/sram_train_ctrl.sv - single-port SRAM with host access and a self-training engine
//
// Purpose:
//   Word-addressed storage for the boot/config path. The host can write while
//   boot_mode=0 and read while boot_mode=1, but only when the training engine
//   is idle. Training writes the pattern (i+1) to every word, reads each word
//   back and counts mismatches. The top RSVD bits of every word always hold 0.
//
// Ports:
//   clk, rstn            clock (rising edge), synchronous active-low reset
//   boot_mode            1: host reads allowed, 0: host writes allowed
//   wren, rden, addr     host request strobes and word address
//   data_in              host write data
//   data_out, rd_valid   read data (held between reads) and its 1-cycle strobe
//   access_err           1-cycle strobe for a rejected host request
//   train_start          start a training run (only honoured in IDLE)
//   inj_en, inj_addr     fault injection: flip bit 0 of the pattern at inj_addr
//   train_busy           training in progress
//   train_done           1-cycle strobe at the end of a training run
//   train_pass           last run saw zero mismatches
//   err_count            mismatch count of the last run, saturating at DEPTH

module sram_train_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int RSVD  = 4,
    localparam int ADDR = $clog2(DEPTH),
    localparam int ECW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             boot_mode,
    input  logic             wren,
    input  logic             rden,
    input  logic [ADDR-1:0]  addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             access_err,
    input  logic             train_start,
    input  logic             inj_en,
    input  logic [ADDR-1:0]  inj_addr,
    output logic             train_busy,
    output logic             train_done,
    output logic             train_pass,
    output logic [ECW-1:0]   err_count
);

    // Ones in the usable low bits, zeros in the reserved high bits.
    localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} >> RSVD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CHK
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [ADDR-1:0]  idx_q;
    logic             last_idx;

    // Read-back pipeline: the word read in RD is compared one cycle later.
    logic             chk_valid_q;
    logic [ADDR-1:0]  chk_idx_q;
    logic [WIDTH-1:0] chk_data_q;

    logic             addr_ok;
    logic             idle;
    logic             host_wr_ok;
    logic             host_rd_ok;
    logic             host_err;
    logic             inj_hit;
    logic [WIDTH-1:0] train_wdata;
    logic [WIDTH-1:0] chk_expect;
    logic             mismatch;
    logic [ECW-1:0]   err_next;

    // Expected training pattern for word i: (i+1) mod 2^WIDTH, reserved bits cleared.
    function automatic logic [WIDTH-1:0] pattern(input logic [ADDR-1:0] i);
        return (WIDTH'(i) + WIDTH'(1)) & MASK;
    endfunction

    // When DEPTH fills the address space every address is valid; otherwise
    // reject the tail addresses so they never index past the array.
    generate
        if (DEPTH == (1 << ADDR)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_part
            assign addr_ok = ({1'b0, addr} < (ADDR + 1)'(DEPTH));
        end
    endgenerate

    assign idle       = (state_q == S_IDLE);
    assign train_busy = ~idle;
    assign last_idx   = (idx_q == ADDR'(DEPTH - 1));

    // Host request decode. Anything requested that is not a clean write or a
    // clean read is an error, including every request while training runs.
    always_comb begin
        host_wr_ok = wren & ~rden & ~boot_mode & idle & addr_ok;
        host_rd_ok = rden & ~wren &  boot_mode & idle & addr_ok;
        host_err   = (wren | rden) & ~host_wr_ok & ~host_rd_ok;
    end

    // Training write data, with optional bit-0 flip at the injection address.
    always_comb begin
        inj_hit     = inj_en & (inj_addr == idx_q);
        train_wdata = pattern(idx_q) ^ WIDTH'(inj_hit);
    end

    // Mismatch accounting for the word read back in the previous cycle.
    always_comb begin
        chk_expect = pattern(chk_idx_q);
        mismatch   = chk_valid_q & (chk_data_q != chk_expect);
        err_next   = err_count;
        if (mismatch && (err_count != ECW'(DEPTH))) begin
            err_next = err_count + ECW'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (train_start) state_d = S_WR;
            S_WR:    if (last_idx)    state_d = S_RD;
            S_RD:    if (last_idx)    state_d = S_CHK;
            S_CHK:                    state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, memory and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            idx_q       <= '0;
            chk_valid_q <= 1'b0;
            chk_idx_q   <= '0;
            chk_data_q  <= '0;
            data_out    <= '0;
            rd_valid    <= 1'b0;
            access_err  <= 1'b0;
            train_done  <= 1'b0;
            train_pass  <= 1'b0;
            err_count   <= '0;
        end else begin
            rd_valid    <= 1'b0;
            train_done  <= 1'b0;
            chk_valid_q <= 1'b0;
            access_err  <= host_err;

            // Host traffic is only accepted in IDLE, so it never collides
            // with the training port below.
            if (host_wr_ok) begin
                mem[addr] <= data_in & MASK;
            end
            if (host_rd_ok) begin
                data_out <= mem[addr];
                rd_valid <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (train_start) begin
                        idx_q      <= '0;
                        err_count  <= '0;
                        train_pass <= 1'b0;
                    end
                end
                S_WR: begin
                    mem[idx_q] <= train_wdata;
                    idx_q      <= last_idx ? '0 : idx_q + ADDR'(1);
                end
                S_RD: begin
                    chk_data_q  <= mem[idx_q];
                    chk_idx_q   <= idx_q;
                    chk_valid_q <= 1'b1;
                    idx_q       <= last_idx ? '0 : idx_q + ADDR'(1);
                    err_count   <= err_next;
                end
                S_CHK: begin
                    // The last word's comparison lands here, so the pass flag
                    // is taken from the updated count, not the registered one.
                    err_count  <= err_next;
                    train_pass <= (err_next == '0);
                    train_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
